// File: rtl/gcd_coproc.sv
// gcd_coproc: subtract-based Euclid GCD co-processor for the relprime core.
// Accepts a/b on start, iterates larger-minus-smaller until one operand is
// zero or both are equal, then holds gcd_out/coprime with done high.
// Optional feature macro: GCD_ITER_COUNT_EN builds the saturating
// subtraction counter behind iter_count; without it iter_count is tied to 0.
module gcd_coproc #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] gcd_out,
   output logic             coprime,
   output logic [15:0]      iter_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r, state_n_s;
   logic [WIDTH-1:0] a_r, a_n_s;
   logic [WIDTH-1:0] b_r, b_n_s;
   logic [WIDTH-1:0] gcd_r, gcd_n_s;
   logic             cop_r, cop_n_s;
   logic             busy_r, busy_n_s;
   logic             done_r, done_n_s;
   logic [WIDTH-1:0] res_s;
   logic             fin_s;

`ifdef GCD_ITER_COUNT_EN
   logic [15:0]      cnt_r, cnt_n_s;
   logic [15:0]      iter_r, iter_n_s;
`endif

   // Next-state, datapath and output-register updates for the GCD FSM.
   always_comb begin
      state_n_s = state_r;
      a_n_s     = a_r;
      b_n_s     = b_r;
      gcd_n_s   = gcd_r;
      cop_n_s   = cop_r;
      busy_n_s  = busy_r;
      done_n_s  = done_r;
      res_s     = ZERO;
      fin_s     = 1'b0;
`ifdef GCD_ITER_COUNT_EN
      cnt_n_s   = cnt_r;
      iter_n_s  = iter_r;
`endif
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               // Accept: latch operands, drop the previous result.
               state_n_s = ST_RUN;
               a_n_s     = a;
               b_n_s     = b;
               busy_n_s  = 1'b1;
               done_n_s  = 1'b0;
               gcd_n_s   = ZERO;
               cop_n_s   = 1'b0;
`ifdef GCD_ITER_COUNT_EN
               cnt_n_s   = 16'd0;
               iter_n_s  = 16'd0;
`endif
            end else begin
               state_n_s = state_r;
            end
         end
         ST_RUN: begin
            // Termination checks in priority order; otherwise subtract the
            // smaller operand from the larger one (never underflows).
            if ((a_r == ZERO) && (b_r == ZERO)) begin
               fin_s = 1'b1;
               res_s = ZERO;
            end else if (a_r == ZERO) begin
               fin_s = 1'b1;
               res_s = b_r;
            end else if (b_r == ZERO) begin
               fin_s = 1'b1;
               res_s = a_r;
            end else if (a_r == b_r) begin
               fin_s = 1'b1;
               res_s = a_r;
            end else if (a_r > b_r) begin
               a_n_s = a_r - b_r;
`ifdef GCD_ITER_COUNT_EN
               cnt_n_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
`endif
            end else begin
               b_n_s = b_r - a_r;
`ifdef GCD_ITER_COUNT_EN
               cnt_n_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
`endif
            end

            if (fin_s) begin
               state_n_s = ST_DONE;
               busy_n_s  = 1'b0;
               done_n_s  = 1'b1;
               gcd_n_s   = res_s;
               cop_n_s   = (res_s == ONE);
`ifdef GCD_ITER_COUNT_EN
               iter_n_s  = cnt_r;
`endif
            end else begin
               state_n_s = ST_RUN;
            end
         end
         default: begin
            // Unreachable encoding: recover to a clean idle state.
            state_n_s = ST_IDLE;
            busy_n_s  = 1'b0;
            done_n_s  = 1'b0;
            gcd_n_s   = ZERO;
            cop_n_s   = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r <= ST_IDLE;
         a_r     <= ZERO;
         b_r     <= ZERO;
         gcd_r   <= ZERO;
         cop_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
         cnt_r   <= 16'd0;
         iter_r  <= 16'd0;
`endif
      end else begin
         state_r <= state_n_s;
         a_r     <= a_n_s;
         b_r     <= b_n_s;
         gcd_r   <= gcd_n_s;
         cop_r   <= cop_n_s;
         busy_r  <= busy_n_s;
         done_r  <= done_n_s;
`ifdef GCD_ITER_COUNT_EN
         cnt_r   <= cnt_n_s;
         iter_r  <= iter_n_s;
`endif
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign gcd_out = gcd_r;
   assign coprime = cop_r;
`ifdef GCD_ITER_COUNT_EN
   assign iter_count = iter_r;
`else
   assign iter_count = 16'd0;
`endif

endmodule

// File: tb/tb_gcd_coproc.sv
// Self-checking bench for gcd_coproc: table-driven GCD vectors plus
// hand-written sequences for start-in-RUN, back-to-back start and reset
// during a long computation. Honours GCD_ITER_COUNT_EN for iter_count.
module tb_gcd_coproc;

   localparam int WIDTH = 16;

   logic             CLK;
   logic             RST_N;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] gcd_out;
   logic             coprime;
   logic [15:0]      iter_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic [15:0] exp_gcd;
      logic        exp_cop;
      int          exp_s;
   } vec_t;

   vec_t vecs [12];

   gcd_coproc #(.WIDTH(WIDTH)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .gcd_out    (gcd_out),
      .coprime    (coprime),
      .iter_count (iter_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_iter(input int s);
`ifdef GCD_ITER_COUNT_EN
      return s[15:0];
`else
      return (s == 0) ? 16'd0 : 16'd0;
`endif
   endfunction

   // busy and done must never be high together.
   always @(negedge CLK) begin
      if (RST_N === 1'b1) begin
         chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      end
   end

   task automatic wait_done(input string name, input int limit, output int n);
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         @(posedge CLK); #1;
         n++;
      end
      if (done !== 1'b1) begin
         chk({name, "_timeout"}, {31'd0, done}, 32'd1);
      end
   endtask

   task automatic run_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] eg, input logic ec, input int s);
      int n;
      @(negedge CLK);
      a = va; b = vb; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF;
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
      chk({name, "_done_low"}, {31'd0, done}, 32'd0);
      wait_done(name, 200, n);
      chk({name, "_latency"}, n, s + 1);
      chk({name, "_gcd"}, {16'd0, gcd_out}, {16'd0, eg});
      chk({name, "_coprime"}, {31'd0, coprime}, {31'd0, ec});
      chk({name, "_iter"}, {16'd0, iter_count}, {16'd0, exp_iter(s)});
      chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      vecs[0]  = '{16'd12,    16'd8,     16'd4,    1'b0, 2};
      vecs[1]  = '{16'd35,    16'd4,     16'd1,    1'b1, 11};
      vecs[2]  = '{16'd7,     16'd7,     16'd7,    1'b0, 0};
      vecs[3]  = '{16'd0,     16'd9,     16'd9,    1'b0, 0};
      vecs[4]  = '{16'd0,     16'd0,     16'd0,    1'b0, 0};
      vecs[5]  = '{16'd9,     16'd0,     16'd9,    1'b0, 0};
      vecs[6]  = '{16'd1,     16'd0,     16'd1,    1'b1, 0};
      vecs[7]  = '{16'd0,     16'd1,     16'd1,    1'b1, 0};
      vecs[8]  = '{16'd17,    16'd5,     16'd1,    1'b1, 6};
      vecs[9]  = '{16'd9,     16'd6,     16'd3,    1'b0, 2};
      vecs[10] = '{16'hFFFF,  16'hFFFF,  16'hFFFF, 1'b0, 0};
      vecs[11] = '{16'h8000,  16'h4000,  16'h4000, 1'b0, 1};

      RST_N = 1'b0; start = 1'b0; a = 16'd0; b = 16'd0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_gcd", {16'd0, gcd_out}, 32'd0);
      chk("rst_coprime", {31'd0, coprime}, 32'd0);
      chk("rst_iter", {16'd0, iter_count}, 32'd0);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                vecs[i].exp_gcd, vecs[i].exp_cop, vecs[i].exp_s);
      end

      // Start during RUN is ignored; start in first DONE cycle restarts.
      @(negedge CLK);
      a = 16'd12; b = 16'd8; start = 1'b1;
      @(posedge CLK); #1;
      a = 16'd5; b = 16'd5; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      chk("ign_busy_k1", {31'd0, busy}, 32'd1);
      @(posedge CLK); #1;
      chk("ign_done_k2", {31'd0, done}, 32'd0);
      @(posedge CLK); #1;
      chk("ign_done_k3", {31'd0, done}, 32'd1);
      chk("ign_gcd", {16'd0, gcd_out}, 32'd4);
      a = 16'd9; b = 16'd6; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      chk("b2b_done_drop", {31'd0, done}, 32'd0);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_gcd_cleared", {16'd0, gcd_out}, 32'd0);
      wait_done("b2b", 200, n);
      chk("b2b_latency", n, 32'd3);
      chk("b2b_gcd", {16'd0, gcd_out}, 32'd3);

      // Reset in the middle of a long computation.
      @(negedge CLK);
      a = 16'hFFFF; b = 16'd1; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (99) @(posedge CLK);
      #1;
      chk("long_busy", {31'd0, busy}, 32'd1);
      RST_N = 1'b0;
      @(posedge CLK); #1;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      chk("mrst_gcd", {16'd0, gcd_out}, 32'd0);
      chk("mrst_coprime", {31'd0, coprime}, 32'd0);
      chk("mrst_iter", {16'd0, iter_count}, 32'd0);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("mrst_idle", {31'd0, busy}, 32'd0);
      run_op("after_rst", 16'd6, 16'd4, 16'd2, 1'b0, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
